// File: rtl/mc_pkg.sv
// Shared types for the multicast bus transmitter: packet layout, FSM states, drop counter width.
// mc_pkt_t is the default-width packet; parameterised instances build the same layout locally.
package mc_pkg;

    localparam int DROP_CNT_W    = 16;
    localparam int MC_DEF_DATA_W = 16;
    localparam int MC_DEF_ID_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } mc_tx_state_e;

    typedef struct packed {
        logic [MC_DEF_ID_W-1:0]   tag;
        logic [MC_DEF_DATA_W-1:0] data;
    } mc_pkt_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mc_pkt_fifo.sv
// Synchronous packet FIFO, zero-latency read of the head entry, full/empty flags.
// A push while full is accepted only together with a pop (the popped slot is reused).
module mc_pkt_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdat,
    input  logic         pop,
    output logic [W-1:0] rdat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdat    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdat;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_bus_tx.sv
// Multicast X-bus transmitter: delivers each buffered packet to every caster whose ID equals its tag.
// Load one cycle after the FIFO write; a packet retires once every matched caster has taken it.
module mc_bus_tx
    import mc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int ID_W       = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    parameter int FIFO_DEPTH = 2,
    parameter int COL_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [COL_W-1:0]        cfg_col,
    input  logic [ID_W-1:0]         cfg_id,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ID_W-1:0]         in_tag,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [DATA_WIDTH-1:0]   bus_data,
    output logic [ID_W-1:0]         bus_tag,
    output logic [NUM_COL*ID_W-1:0] caster_id,
    output logic [NUM_COL-1:0]      caster_en,
    input  logic [NUM_COL-1:0]      caster_ready,
    output logic                    busy,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);
    localparam int PKT_W = ID_W + DATA_WIDTH;

    mc_tx_state_e                 state;
    logic [NUM_COL-1:0][ID_W-1:0] id_tbl;
    logic [NUM_COL-1:0]           match;
    logic [NUM_COL-1:0]           done_mask;
    logic [NUM_COL-1:0]           head_match;
    logic [NUM_COL-1:0]           xfer;
    logic [PKT_W-1:0]             head;
    logic [ID_W-1:0]              head_tag;
    logic [DATA_WIDTH-1:0]        head_data;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         push;
    logic                         all_done;
    logic                         load;
    logic                         cfg_hit;

    assign in_ready = !fifo_full && !rst;
    assign push     = in_valid && in_ready;

    mc_pkt_fifo #(
        .W     (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdat  ({in_tag, in_data}),
        .pop   (load),
        .rdat  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_tag  = head[PKT_W-1 -: ID_W];
    assign head_data = head[DATA_WIDTH-1:0];

    always_comb begin
        head_match = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            head_match[c] = (id_tbl[c] == head_tag);
        end
    end

    // Enables decode purely from registered state, so they never glitch on caster_ready.
    assign caster_en = (state == SEND) ? (match & ~done_mask) : '0;
    assign xfer      = caster_en & caster_ready;
    assign all_done  = (state == SEND) && (&(done_mask | xfer));
    assign load      = !fifo_empty && ((state == IDLE) || all_done);
    assign busy      = (state == SEND) || !fifo_empty;
    assign caster_id = id_tbl;
    assign cfg_hit   = cfg_we && (32'(cfg_col) < 32'(NUM_COL));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            match     <= '0;
            done_mask <= '0;
            bus_data  <= '0;
            bus_tag   <= '0;
            drop_cnt  <= '0;
            for (int c = 0; c < NUM_COL; c++) begin
                id_tbl[c] <= ID_W'(c);
            end
        end else begin
            if (cfg_hit) begin
                id_tbl[cfg_col] <= cfg_id;
            end
            if (state == SEND) begin
                done_mask <= done_mask | xfer;
            end
            if (load) begin
                // A packet nobody listens to is consumed here without touching the bus.
                if (head_match == '0) begin
                    drop_cnt <= sat_inc(drop_cnt);
                    state    <= IDLE;
                end else begin
                    bus_data  <= head_data;
                    bus_tag   <= head_tag;
                    match     <= head_match;
                    done_mask <= ~head_match;
                    state     <= SEND;
                end
            end else if (all_done) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mc_bus_tx.sv
// Bench for mc_bus_tx: directed scenarios plus randomized traffic checked against per-caster expectation queues.
module tb_mc_bus_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_col;
    logic [1:0]  cfg_id;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_tag;
    logic [15:0] in_data;
    logic [15:0] bus_data;
    logic [1:0]  bus_tag;
    logic [7:0]  caster_id;
    logic [3:0]  caster_en;
    logic [3:0]  caster_ready;
    logic        busy;
    logic [15:0] drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0]  mdl_id [4];
    logic [17:0] exp_q [4][$];
    int          exp_drops;
    logic [17:0] exp_pkt;
    logic        rnd_done;

    always #5 clk = ~clk;

    mc_bus_tx #(
        .DATA_WIDTH (16),
        .NUM_COL    (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_col      (cfg_col),
        .cfg_id       (cfg_id),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .in_data      (in_data),
        .bus_data     (bus_data),
        .bus_tag      (bus_tag),
        .caster_id    (caster_id),
        .caster_en    (caster_en),
        .caster_ready (caster_ready),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mdl_ids();
        logic [7:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c*2 +: 2] = mdl_id[c];
        return v;
    endfunction

    task automatic mdl_reset();
        for (int c = 0; c < 4; c++) begin
            mdl_id[c] = 2'(c);
            exp_q[c].delete();
        end
        exp_drops = 0;
    endtask

    task automatic cfg(input int c, input logic [1:0] v);
        cfg_we  = 1'b1;
        cfg_col = 2'(c);
        cfg_id  = v;
        tick();
        cfg_we     = 1'b0;
        mdl_id[c]  = v;
    endtask

    // Packet is expected at every caster whose ID equals the tag at acceptance time.
    task automatic push(input logic [1:0] tag, input logic [15:0] data);
        int hits;
        in_valid = 1'b1;
        in_tag   = tag;
        in_data  = data;
        for (int i = 0; i < 500; i++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                hits = 0;
                for (int c = 0; c < 4; c++) begin
                    if (mdl_id[c] == tag) begin
                        exp_q[c].push_back({tag, data});
                        hits++;
                    end
                end
                if (hits == 0) exp_drops++;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (!busy) return;
            tick();
        end
        chk("idle_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                if (caster_en[c] && caster_ready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        chk("xfer_extra", 32'(c), 32'hFF);
                    end else begin
                        exp_pkt = exp_q[c].pop_front();
                        chk("xfer_pkt", {14'd0, bus_tag, bus_data}, {14'd0, exp_pkt});
                    end
                end
                if (caster_en[c] && (mdl_id[c] != bus_tag)) chk("en_nomatch", 32'(c), 32'hFF);
            end
        end
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_col = '0; cfg_id = '0;
        in_valid = 1'b0; in_tag = '0; in_data = '0; caster_ready = '0;
        rnd_done = 1'b0;
        mdl_reset();

        // Reset
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_caster_id", 32'(caster_id), 32'hE4);
        chk("rst_caster_en", 32'(caster_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_bus_data", 32'(bus_data), 0);
        chk("rst_in_ready_after", 32'(in_ready), 1);

        // Unicast
        caster_ready = 4'hF;
        push(2'd2, 16'hA5A5);
        chk("uni_latency_en", 32'(caster_en), 0);
        tick();
        chk("uni_en", 32'(caster_en), 32'h4);
        chk("uni_data", 32'(bus_data), 32'hA5A5);
        tick();
        chk("uni_en_off", 32'(caster_en), 0);
        chk("uni_busy", 32'(busy), 0);

        // Multicast with staggered readiness
        cfg(0, 2'd1); cfg(1, 2'd1); cfg(2, 2'd1); cfg(3, 2'd0);
        chk("mc_caster_id", 32'(caster_id), 32'(mdl_ids()));
        caster_ready = 4'h0;
        push(2'd1, 16'h1234);
        tick();
        caster_ready = 4'b0001;
        chk("mc_en0", 32'(caster_en), 32'b0111);
        tick();
        caster_ready = 4'b0000;
        chk("mc_en1", 32'(caster_en), 32'b0110);
        tick();
        caster_ready = 4'b0100;
        chk("mc_en2", 32'(caster_en), 32'b0110);
        tick();
        caster_ready = 4'b0010;
        chk("mc_en3", 32'(caster_en), 32'b0010);
        chk("mc_bus_stable", 32'(bus_data), 32'h1234);
        tick();
        chk("mc_en4", 32'(caster_en), 0);
        chk("mc_busy", 32'(busy), 0);

        // Drop: no caster holds ID 3
        cfg(0, 2'd0); cfg(1, 2'd0); cfg(2, 2'd1); cfg(3, 2'd1);
        push(2'd3, 16'hDEAD);
        chk("drop_before", 32'(drop_cnt), 0);
        tick();
        chk("drop_after", 32'(drop_cnt), 1);
        chk("drop_en", 32'(caster_en), 0);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_bus_kept", 32'(bus_data), 32'h1234);

        // Backpressure
        caster_ready = 4'h0;
        push(2'd0, 16'h0001);
        push(2'd1, 16'h0002);
        chk("bp_ready_2", 32'(in_ready), 1);
        push(2'd0, 16'h0003);
        chk("bp_ready_3", 32'(in_ready), 0);
        caster_ready = 4'hF;
        wait_idle();
        tick();
        for (int c = 0; c < 4; c++) chk("bp_drained", 32'(exp_q[c].size()), 0);

        // Reset while sending
        cfg(0, 2'd0); cfg(1, 2'd1); cfg(2, 2'd2); cfg(3, 2'd3);
        caster_ready = 4'h0;
        push(2'd1, 16'hBEEF);
        push(2'd3, 16'hCAFE);
        chk("rms_en", 32'(caster_en), 32'b0010);
        rst = 1'b1;
        tick();
        chk("rms_en_off", 32'(caster_en), 0);
        chk("rms_busy", 32'(busy), 0);
        chk("rms_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        mdl_reset();
        tick();
        chk("rms_in_ready_after", 32'(in_ready), 1);
        chk("rms_caster_id", 32'(caster_id), 32'(mdl_ids()));

        // Randomized traffic
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    caster_ready = 4'($urandom);
                end
            end
            begin
                for (int r = 0; r < 3; r++) begin
                    wait_idle();
                    for (int c = 0; c < 4; c++) cfg(c, 2'($urandom_range(0, 3)));
                    chk("rnd_caster_id", 32'(caster_id), 32'(mdl_ids()));
                    for (int p = 0; p < 40; p++) begin
                        push(2'($urandom_range(0, 3)), 16'($urandom));
                        if ($urandom_range(0, 3) == 0) tick();
                    end
                end
                rnd_done = 1'b1;
            end
        join
        caster_ready = 4'hF;
        wait_idle();
        tick();
        for (int c = 0; c < 4; c++) chk("rnd_drained", 32'(exp_q[c].size()), 0);
        chk("rnd_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
